// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: video timing bundle between the sync generator and the
// renderer / output pin mux.
//   pix_ce       pixel clock enable, supplied by the consumer side
//   hsync/vsync  registered sync pulses
//   display_on   beam inside the visible area
//   hpos/vpos    beam column / line
//   line_start   one-pixel pulse at hpos==0
//   frame_start  one-pixel pulse at hpos==0 && vpos==0
interface vga_sync_gen_if;
    logic       pix_ce;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       line_start;
    logic       frame_start;

    modport master (
        input  pix_ce,
        output hsync, vsync, display_on, hpos, vpos, line_start, frame_start
    );

    modport slave (
        output pix_ce,
        input  hsync, vsync, display_on, hpos, vpos, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA pixel timing generator (default 640x480@60).
//   clk    system / pixel clock
//   rst_n  asynchronous active-low reset
//   vid    timing bundle (master side): pix_ce in; syncs, position,
//          display_on and line/frame pulses out, all registered.
// Every output is decoded from the next counter values and registered in
// the same flop stage as the counters, so outputs line up with hpos/vpos
// and no combinational decode drives a pin.
module vga_sync_gen #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    vga_sync_gen_if.master vid
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
            $error("vga_sync_gen: H_TOTAL/V_TOTAL do not fit 10-bit counters");
        end
    endgenerate

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Range bounds kept at 11 bits so an end bound of exactly 1024 still works.
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] HS_BEGIN = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
    localparam logic [10:0] VS_BEGIN = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [9:0] hpos_q, vpos_q, hpos_nxt, vpos_nxt;
    logic       hsync_q, vsync_q, display_on_q, line_start_q, frame_start_q;
    logic       in_hsync, in_vsync, visible;

    always_comb begin
        hpos_nxt = hpos_q + 10'd1;
        vpos_nxt = vpos_q;
        if (hpos_q == H_LAST) begin
            hpos_nxt = '0;
            vpos_nxt = (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;
        end
    end

    always_comb begin
        in_hsync = ({1'b0, hpos_nxt} >= HS_BEGIN) && ({1'b0, hpos_nxt} < HS_END);
        in_vsync = ({1'b0, vpos_nxt} >= VS_BEGIN) && ({1'b0, vpos_nxt} < VS_END);
        visible  = ({1'b0, hpos_nxt} < H_VIS) && ({1'b0, vpos_nxt} < V_VIS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q        <= H_LAST;
            vpos_q        <= V_LAST;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            display_on_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (vid.pix_ce) begin
            hpos_q        <= hpos_nxt;
            vpos_q        <= vpos_nxt;
            hsync_q       <= in_hsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_q       <= in_vsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            display_on_q  <= visible;
            line_start_q  <= (hpos_nxt == '0);
            frame_start_q <= (hpos_nxt == '0) && (vpos_nxt == '0);
        end
    end

    assign vid.hpos        = hpos_q;
    assign vid.vpos        = vpos_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.display_on  = display_on_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;

endmodule
